btn_scan_4: RTL and testbench

//   Input-side companion to the 4-LED output driver. Samples four raw push-button

---
 rtl/btn_scan_4.sv | 118 +++++++++++
 tb/tb_btn_scan_4.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_scan_4.sv
// Four-button front end: two-flop synchronisers, per-button debounce, and a small
// event FIFO reporting each accepted press/release to a valid/ready consumer.
module btn_scan_4 #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 25,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_1,
    input  logic       btn_2,
    input  logic       btn_3,
    input  logic       btn_4,
    output logic [3:0] btn_state,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_code,
    output logic       evt_press,
    output logic       evt_overflow
);

    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       btn_raw;
    logic [3:0]       sync1, sync2;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       accept;
    logic [3:0]       pending, pdir, clr;
    logic [1:0]       sel;
    logic             any_pend;
    logic [2:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop;

    assign btn_raw = {btn_4, btn_3, btn_2, btn_1};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < 4; i++)
            accept[i] = (sync2[i] != btn_state[i]) && (cnt[i] == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            btn_state <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == btn_state[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    cnt[i]       <= '0;
                    btn_state[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Fixed priority: lowest-index pending button wins the single push slot.
    always_comb begin
        sel      = 2'd0;
        any_pend = |pending;
        for (int i = 3; i >= 0; i--)
            if (pending[i]) sel = 2'(i);
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && evt_ready;
    assign push  = any_pend && (!full || pop);
    assign clr   = push ? (4'b0001 << sel) : 4'b0000;

    // A fresh acceptance on a still-pending button overwrites its direction and
    // loses the earlier event; one being pushed this edge is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= '0;
            pdir         <= '0;
            evt_overflow <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | accept;
            for (int i = 0; i < 4; i++)
                if (accept[i]) pdir[i] <= sync2[i];
            if (|(pending & ~clr & accept)) evt_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {sel, pdir[sel]};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign evt_valid            = !empty;
    assign {evt_code, evt_press} = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_btn_scan_4.sv
// Bench for btn_scan_4: directed scenarios plus random button/ready traffic,
// compared every cycle against a queue-based behavioural model.
module tb_btn_scan_4;

    localparam int D     = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic       evt_ready = 1'b0;
    logic [3:0] btn_state;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_press;
    logic       evt_overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    btn_scan_4 #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .btn_1(btn[0]), .btn_2(btn[1]), .btn_3(btn[2]), .btn_4(btn[3]),
        .btn_state(btn_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_press(evt_press), .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: raw level delayed two samples, accepted after D
    // consecutive differing samples; events kept in a queue.
    logic [3:0] m_s1, m_s2, m_state, m_pend, m_pdir;
    int         m_streak [4];
    bit         m_ovf;
    logic [2:0] m_q [$];
    logic [2:0] popped [$];
    int         popped_cyc [$];

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_state = '0; m_pend = '0; m_pdir = '0;
        for (int i = 0; i < 4; i++) m_streak[i] = 0;
        m_ovf = 0;
        m_q.delete();
    endfunction

    function automatic void model_step();
        bit         do_pop, do_push;
        int         sel;
        logic [3:0] acc;
        if (rst) begin
            model_reset();
            return;
        end
        do_pop = (m_q.size() > 0) && evt_ready;
        sel = -1;
        for (int i = 0; i < 4; i++)
            if (m_pend[i] && sel < 0) sel = i;
        do_push = (sel >= 0) && ((m_q.size() < DEPTH) || do_pop);
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_state[i]) begin
                m_streak[i]++;
                if (m_streak[i] == D) begin
                    acc[i] = 1'b1;
                    m_streak[i] = 0;
                end
            end else begin
                m_streak[i] = 0;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            m_q.push_back({2'(sel), m_pdir[sel]});
            m_pend[sel] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                if (m_pend[i]) m_ovf = 1;
                m_pend[i]  = 1'b1;
                m_pdir[i]  = m_s2[i];
                m_state[i] = m_s2[i];
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        check("btn_state", {4'b0, btn_state}, {4'b0, m_state});
        check("evt_valid", {7'b0, evt_valid}, {7'b0, m_q.size() != 0});
        check("evt_overflow", {7'b0, evt_overflow}, {7'b0, m_ovf});
        if (m_q.size() != 0)
            check("evt_head", {5'b0, evt_code, evt_press}, {5'b0, m_q[0]});
    endtask

    task automatic tick();
        model_step();
        if (evt_valid && evt_ready) begin
            popped.push_back({evt_code, evt_press});
            popped_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        model_reset();
        // Reset with all buttons held, then fresh presses in index order
        rst = 1'b1; btn = 4'b1111; evt_ready = 1'b0;
        run(3);
        check("rst_outputs", {btn_state, evt_valid, evt_code, evt_press},
              {4'b0000, 1'b0, 2'b00, 1'b0});
        rst = 1'b0; evt_ready = 1'b1;
        popped.delete();
        run(20);
        check("rst_evt_count", 8'(popped.size()), 8'd4);
        if (popped.size() == 4) begin
            check("rst_evt0", {5'b0, popped[0]}, 8'b001);
            check("rst_evt1", {5'b0, popped[1]}, 8'b011);
            check("rst_evt2", {5'b0, popped[2]}, 8'b101);
            check("rst_evt3", {5'b0, popped[3]}, 8'b111);
        end
        btn = 4'b0000;
        run(30);

        // Clean press on btn_2 with exact edge latency
        btn = 4'b0010;
        run(9);
        check("press_before_edge9", {4'b0, btn_state}, 8'b0000);
        tick();
        check("press_edge9", {4'b0, btn_state}, 8'b0010);
        tick();
        check("press_valid_edge10", {4'b0, evt_valid, evt_code, evt_press}, 8'b1011);
        tick();
        check("press_single", {7'b0, evt_valid}, 8'd0);

        // Bounce on btn_3: short pulse must not produce an event
        popped.delete();
        btn = 4'b0110; run(5);
        btn = 4'b0010; run(1);
        btn = 4'b0110; run(20);
        run(10);
        check("bounce_count", 8'(popped.size()), 8'd1);
        if (popped.size() == 1) check("bounce_evt", {5'b0, popped[0]}, 8'b101);

        // Simultaneous btn_1 and btn_4 presses
        popped.delete(); popped_cyc.delete();
        btn = 4'b1111;
        run(16);
        check("simul_count", 8'(popped.size()), 8'd2);
        if (popped.size() == 2) begin
            check("simul_first", {5'b0, popped[0]}, 8'b001);
            check("simul_second", {5'b0, popped[1]}, 8'b111);
            check("simul_gap", 8'(popped_cyc[1] - popped_cyc[0]), 8'd1);
        end
        btn = 4'b0000;
        run(20);

        // Backpressure: four queued, fifth held pending
        evt_ready = 1'b0;
        btn = 4'b0001; run(12);
        btn = 4'b0011; run(12);
        btn = 4'b0111; run(12);
        btn = 4'b1111; run(12);
        btn = 4'b1110; run(12);
        check("bp_no_overflow", {7'b0, evt_overflow}, 8'd0);
        check("bp_head", {5'b0, evt_valid, evt_code, evt_press}, 8'b1001);
        popped.delete();
        evt_ready = 1'b1;
        run(8);
        check("bp_drain_count", 8'(popped.size()), 8'd5);
        if (popped.size() == 5) begin
            check("bp_evt0", {5'b0, popped[0]}, 8'b001);
            check("bp_evt1", {5'b0, popped[1]}, 8'b011);
            check("bp_evt2", {5'b0, popped[2]}, 8'b101);
            check("bp_evt3", {5'b0, popped[3]}, 8'b111);
            check("bp_evt4", {5'b0, popped[4]}, 8'b000);
        end

        // Overflow: FIFO full, btn_1 pressed then released while pending
        evt_ready = 1'b0;
        btn = 4'b0000; run(12);
        btn = 4'b0010; run(12);
        btn = 4'b0011; run(12);
        check("ovf_before", {7'b0, evt_overflow}, 8'd0);
        btn = 4'b0010; run(12);
        check("ovf_set", {7'b0, evt_overflow}, 8'd1);
        popped.delete();
        evt_ready = 1'b1;
        run(10);
        check("ovf_drain_count", 8'(popped.size()), 8'd5);
        if (popped.size() == 5) check("ovf_release", {5'b0, popped[4]}, 8'b000);
        evt_ready = 1'b0;
        btn = 4'b0011; run(12);
        check("midq_valid", {7'b0, evt_valid}, 8'd1);
        rst = 1'b1;
        tick();
        check("midq_rst_valid", {7'b0, evt_valid}, 8'd0);
        check("midq_rst_ovf", {7'b0, evt_overflow}, 8'd0);
        rst = 1'b0;

        // Random traffic
        for (int seg = 0; seg < 150; seg++) begin
            btn = 4'($urandom);
            for (int k = 0; k < int'($urandom_range(1, 16)); k++) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        evt_ready = 1'b1;
        run(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
